// File: rtl/sw_input_conditioner_if.sv
// sw_input_conditioner_if: debounced switch word plus its change/valid/ack/overrun handshake.
`timescale 1ns/1ps
interface sw_input_conditioner_if #(
   parameter int WIDTH = 10
) ();
   logic [WIDTH-1:0] SW_o;
   logic             sw_change_o;
   logic             sw_valid_o;
   logic             sw_ack_i;
   logic             sw_overrun_o;
   modport master (
      output SW_o, sw_change_o, sw_valid_o, sw_overrun_o,
      input  sw_ack_i
   );
   modport slave (
      input  SW_o, sw_change_o, sw_valid_o, sw_overrun_o,
      output sw_ack_i
   );
endinterface

// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: synchronises and debounces slide switches, committing whole words
// with a change pulse and a valid/ack handshake that flags overruns.
`timescale 1ns/1ps
module sw_input_conditioner #(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      SW_raw_i,
   sw_input_conditioner_if.master sw_if
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   typedef enum logic {STABLE, SETTLE} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_s1, r_s2, r_cand, r_sw;
   logic [CNT_W-1:0] r_cnt;
   logic             r_change, r_valid, r_overrun;
   logic             w_commit;
   // Commit only when the candidate has held for the full window and still differs from SW_o
   assign w_commit = (r_state == SETTLE) && (r_s2 != r_sw) && (r_s2 == r_cand) && (r_cnt == CNT_MAX);
   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_cand    <= '0;
         r_sw      <= '0;
         r_cnt     <= '0;
         r_change  <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_state   <= STABLE;
      end else begin
         r_s1     <= SW_raw_i;
         r_s2     <= r_s1;
         r_change <= w_commit;
         case (r_state)
            STABLE: if (r_s2 != r_sw) begin
               r_cand  <= r_s2;
               r_cnt   <= '0;
               r_state <= SETTLE;
            end
            SETTLE: if (r_s2 == r_sw) begin
               r_cnt   <= '0;
               r_state <= STABLE;
            end else if (r_s2 != r_cand) begin
               r_cand <= r_s2;
               r_cnt  <= '0;
            end else if (w_commit) begin
               r_sw    <= r_cand;
               r_state <= STABLE;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         endcase
         r_valid <= w_commit | (r_valid & ~sw_if.sw_ack_i);
         // A same-edge ack is consumed by the new word, so it neither clears nor raises overrun
         if (w_commit && r_valid && !sw_if.sw_ack_i) r_overrun <= 1'b1;
         else if (sw_if.sw_ack_i && !w_commit) r_overrun <= 1'b0;
      end
   end
   assign sw_if.SW_o         = r_sw;
   assign sw_if.sw_change_o  = r_change;
   assign sw_if.sw_valid_o   = r_valid;
   assign sw_if.sw_overrun_o = r_overrun;
endmodule
